// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- valid/stall sequencer for a linear pipeline of STAGES data
// registers. Generates per-stage load enables and valid flags, inserts
// bubbles behind stalled stages, handles flush and the upstream/downstream
// valid/ready handshakes, and keeps wrapping transfer/stall statistics.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   in_valid     upstream offers an item
//   in_ready     item accepted this cycle (xfer_in = in_valid & in_ready)
//   out_valid    last stage offers a result
//   out_ready    downstream accepts (xfer_out = out_valid & out_ready)
//   stall_req    per stage: stage k cannot pass its item on this cycle
//   flush        discard everything in flight
//   stage_en     load enable of datapath register k
//   stage_valid  stage k holds a valid item
//   occupancy    number of valid stages (registered state, no lookahead)
//   issued_cnt   wrapping count of xfer_in
//   retired_cnt  wrapping count of xfer_out
//   stall_cnt    wrapping count of cycles where a valid stage did not advance
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] src;
  logic [STAGES-1:0] v_nxt;
  logic              xfer_in;
  logic              xfer_out;
  logic              stalled;

  // Ready chain runs from the output back to the input so a full pipe can
  // still accept every cycle when the tail drains. A local carry keeps the
  // chain free of self-referencing vector bits.
  always_comb begin
    logic carry;
    adv   = '0;
    acc   = '0;
    carry = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = v[k] & ~stall_req[k] & carry;
      acc[k] = ~v[k] | adv[k];
      carry  = acc[k];
    end
  end

  assign src      = {adv[STAGES-2:0], in_valid};
  assign stage_en = acc & src & {STAGES{~flush}};

  // Loading wins over leaving; a stage that leaves without a replacement
  // becomes a bubble.
  assign v_nxt = (src & acc) | (v & ~adv);

  assign in_ready  = acc[0] & ~flush;
  assign out_valid = v[STAGES-1] & ~stall_req[STAGES-1] & ~flush;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign stalled   = (|(v & ~adv)) & ~flush;

  assign stage_valid = v;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v           <= '0;
      issued_cnt  <= '0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      v           <= flush ? '0 : v_nxt;
      issued_cnt  <= issued_cnt  + CNT_W'(xfer_in);
      retired_cnt <= retired_cnt + CNT_W'(xfer_out);
      stall_cnt   <= stall_cnt   + CNT_W'(stalled);
    end
  end

endmodule
